// File: rtl/fan_pkg.sv
`default_nettype none
// ============================================================================
// fan_pkg : shared state type, width helpers and target-duty constant function
// Rev 1.0
// ============================================================================
package fan_pkg;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_RAMP   = 2'd1,
      ST_STEADY = 2'd2
   } fan_state_t;

   function automatic int fan_clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Linear stage-to-duty map; the top stage lands exactly on the full period.
   function automatic int fan_target_duty(input int stage, input int period, input int num_stages);
      return (stage * period) / num_stages;
   endfunction

   localparam int c_def_num_stages = 3;
   localparam int c_def_pwm_period = 1000;
   localparam int c_def_stage_w    = fan_clog2(c_def_num_stages + 1);
   localparam int c_def_duty_w     = fan_clog2(c_def_pwm_period + 1);

endpackage
`default_nettype wire

// File: rtl/fan_ctrl_pwm_timebase.sv
`default_nettype none
// ============================================================================
// pwm_timebase : prescaler plus wrapping period counter (also usable as a scan clock)
// Rev 1.0
// ============================================================================
module pwm_timebase
   import fan_pkg::*;
#(
   parameter int PRESC  = 100,
   parameter int PERIOD = 1000,
   parameter int CNT_W  = 10
) (
   input  logic             i_clk,
   input  logic             i_reset,
   output logic             o_tick,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_period_end
);

   localparam int c_presc_w = (fan_clog2(PRESC) > 0) ? fan_clog2(PRESC) : 1;

   logic [c_presc_w-1:0] presc_q, presc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 w_tick;
   logic                 w_cnt_last;

   always_comb begin
      w_tick     = (presc_q == c_presc_w'(PRESC - 1));
      w_cnt_last = (cnt_q == CNT_W'(PERIOD - 1));
      presc_d    = w_tick ? '0 : presc_q + 1'b1;
      cnt_d      = cnt_q;
      if (w_tick) begin
         cnt_d = w_cnt_last ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_tick       = w_tick;
   assign o_cnt        = cnt_q;
   assign o_period_end = w_tick && w_cnt_last;

endmodule
`default_nettype wire

// File: rtl/fan_ctrl_pwm.sv
`default_nettype none
// ============================================================================
// fan_ctrl_pwm : multi-stage fan controller with ramped PWM duty and instant off
// Rev 1.0
// ============================================================================
module fan_ctrl_pwm
   import fan_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int PRESC      = 100,
   parameter int PWM_PERIOD = 1000,
   parameter int DUTY_W     = 10,
   parameter int RAMP_STEP  = 50,
   parameter int STAGE_W    = fan_clog2(NUM_STAGES + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_btn_off,
   input  logic                  i_btn_up,
   input  logic                  i_btn_down,
   input  logic                  i_sel_vld,
   input  logic [STAGE_W-1:0]    i_sel_stage,
   output logic                  o_motor,
   output logic [STAGE_W-1:0]    o_stage,
   output logic [NUM_STAGES-1:0] o_light,
   output logic [DUTY_W-1:0]     o_duty,
   output logic                  o_ramping
);

   logic                  w_tick;
   logic                  w_period_end;
   logic [DUTY_W-1:0]     w_cnt;
   logic [DUTY_W-1:0]     w_target;
   logic [DUTY_W:0]       w_up_sum;
   logic [DUTY_W-1:0]     w_dn_gap;

   logic [STAGE_W-1:0]    stage_q, stage_d;
   logic [DUTY_W-1:0]     duty_q, duty_d;
   logic [NUM_STAGES-1:0] light_q, light_d;
   logic                  motor_q, motor_d;
   fan_state_t            state_q, state_d;

   pwm_timebase #(
      .PRESC  (PRESC),
      .PERIOD (PWM_PERIOD),
      .CNT_W  (DUTY_W)
   ) u_timebase (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .o_tick       (w_tick),
      .o_cnt        (w_cnt),
      .o_period_end (w_period_end)
   );

   // Constant lookup: each branch folds to a literal, no runtime divider.
   always_comb begin
      w_target = '0;
      for (int k = 0; k <= NUM_STAGES; k++) begin
         if (stage_q == STAGE_W'(k)) begin
            w_target = DUTY_W'(fan_target_duty(k, PWM_PERIOD, NUM_STAGES));
         end
      end
   end

   always_comb begin
      stage_d = stage_q;
      if (i_btn_off) begin
         stage_d = '0;
      end else if (i_sel_vld) begin
         if (i_sel_stage <= STAGE_W'(NUM_STAGES)) begin
            stage_d = i_sel_stage;
         end
      end else if (i_btn_up) begin
         if (stage_q < STAGE_W'(NUM_STAGES)) begin
            stage_d = stage_q + 1'b1;
         end
      end else if (i_btn_down) begin
         if (stage_q != '0) begin
            stage_d = stage_q - 1'b1;
         end
      end

      light_d = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         light_d[k] = (stage_d > STAGE_W'(k));
      end
   end

   // One extra bit on the rising sum keeps a large step from wrapping past the target.
   always_comb begin
      w_up_sum = {1'b0, duty_q} + (DUTY_W+1)'(RAMP_STEP);
      w_dn_gap = duty_q - w_target;
      duty_d   = duty_q;
      if (i_btn_off) begin
         duty_d = '0;
      end else if (w_tick && w_period_end) begin
         if (duty_q < w_target) begin
            duty_d = (w_up_sum >= {1'b0, w_target}) ? w_target : w_up_sum[DUTY_W-1:0];
         end else if (duty_q > w_target) begin
            duty_d = ({1'b0, w_dn_gap} > (DUTY_W+1)'(RAMP_STEP)) ?
                     (duty_q - DUTY_W'(RAMP_STEP)) : w_target;
         end
      end
      motor_d = (w_cnt < duty_q);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         stage_q <= '0;
         duty_q  <= '0;
         light_q <= '0;
         motor_q <= 1'b0;
      end else begin
         stage_q <= stage_d;
         duty_q  <= duty_d;
         light_q <= light_d;
         motor_q <= motor_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if ((stage_q == '0) && (duty_q == '0)) begin
         state_d = ST_OFF;
      end else if (duty_q != w_target) begin
         state_d = ST_RAMP;
      end else begin
         state_d = ST_STEADY;
      end
   end

   assign o_stage   = stage_q;
   assign o_light   = light_q;
   assign o_duty    = duty_q;
   assign o_motor   = motor_q;
   assign o_ramping = (state_q == ST_RAMP);

endmodule
`default_nettype wire

// File: tb/tb_fan_ctrl_pwm.sv
`default_nettype none
// ============================================================================
// tb_fan_ctrl_pwm : directed self-checking bench, 3 stages, 20-clock PWM period
// Rev 1.0
// ============================================================================
module tb_fan_ctrl_pwm;

   logic       clk;
   logic       i_reset;
   logic       i_btn_off, i_btn_up, i_btn_down, i_sel_vld;
   logic [2:0] i_sel_stage;
   logic       o_motor;
   logic [2:0] o_stage;
   logic [2:0] o_light;
   logic [3:0] o_duty;
   logic       o_ramping;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int highs;

   fan_ctrl_pwm #(
      .NUM_STAGES (3),
      .PRESC      (2),
      .PWM_PERIOD (10),
      .DUTY_W     (4),
      .RAMP_STEP  (2),
      .STAGE_W    (3)
   ) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_btn_off   (i_btn_off),
      .i_btn_up    (i_btn_up),
      .i_btn_down  (i_btn_down),
      .i_sel_vld   (i_sel_vld),
      .i_sel_stage (i_sel_stage),
      .o_motor     (o_motor),
      .o_stage     (o_stage),
      .o_light     (o_light),
      .o_duty      (o_duty),
      .o_ramping   (o_ramping)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; period ends fall on multiples of 20.
   always @(posedge clk) begin
      if (i_reset) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_pe();
      do step(1); while (cyc % 20 != 0);
   endtask

   task automatic pulse(input logic off, input logic up, input logic dn,
                        input logic sv, input logic [2:0] sel);
      i_btn_off = off; i_btn_up = up; i_btn_down = dn; i_sel_vld = sv; i_sel_stage = sel;
      step(1);
      i_btn_off = 1'b0; i_btn_up = 1'b0; i_btn_down = 1'b0; i_sel_vld = 1'b0; i_sel_stage = 3'd0;
   endtask

   task automatic count_motor(input int n, output int h);
      h = 0;
      for (int i = 0; i < n; i++) begin
         step(1);
         if (o_motor === 1'b1) h++;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_stage"},   32'(o_stage),   0);
      check({tag, "_duty"},    32'(o_duty),    0);
      check({tag, "_light"},   32'(o_light),   0);
      check({tag, "_motor"},   32'(o_motor),   0);
      check({tag, "_ramping"}, 32'(o_ramping), 0);
   endtask

   initial begin
      i_reset = 1'b1;
      i_btn_off = 1'b0; i_btn_up = 1'b0; i_btn_down = 1'b0; i_sel_vld = 1'b0; i_sel_stage = 3'd0;

      // 1: reset and idle
      step(3);
      check_idle("in_reset");
      i_reset = 1'b0;
      step(3);
      check_idle("after_rst");
      count_motor(60, highs);
      check("off_motor_60clk", 32'(highs), 0);

      // 2: up to stage 1, ramp 0->2->3
      pulse(0, 1, 0, 0, 3'd0);
      check("up_stage", 32'(o_stage), 1);
      check("up_light", 32'(o_light), 32'b001);
      step(1);
      check("up_ramping", 32'(o_ramping), 1);
      wait_pe();
      check("s1_duty_pe1", 32'(o_duty), 2);
      wait_pe();
      check("s1_duty_pe2", 32'(o_duty), 3);
      step(1);
      check("s1_steady", 32'(o_ramping), 0);
      count_motor(20, highs);
      check("s1_motor_6of20", 32'(highs), 6);

      // 3: direct select to stage 3, ramp 3->5->7->9->10
      pulse(0, 0, 0, 1, 3'd3);
      check("sel3_stage", 32'(o_stage), 3);
      check("sel3_light", 32'(o_light), 32'b111);
      wait_pe(); check("s3_duty5",  32'(o_duty), 5);
      wait_pe(); check("s3_duty7",  32'(o_duty), 7);
      wait_pe(); check("s3_duty9",  32'(o_duty), 9);
      wait_pe(); check("s3_duty10", 32'(o_duty), 10);
      step(1);
      check("s3_steady", 32'(o_ramping), 0);
      count_motor(20, highs);
      check("s3_motor_full", 32'(highs), 20);

      // 4: down to stage 1 (10->8->6->4->3), reselect 3 (->5->7), then off
      pulse(0, 0, 1, 0, 3'd0);
      pulse(0, 0, 1, 0, 3'd0);
      check("dn_stage1", 32'(o_stage), 1);
      wait_pe(); check("dn_duty8", 32'(o_duty), 8);
      wait_pe(); check("dn_duty6", 32'(o_duty), 6);
      wait_pe(); check("dn_duty4", 32'(o_duty), 4);
      wait_pe(); check("dn_duty3_clamp", 32'(o_duty), 3);
      pulse(0, 0, 0, 1, 3'd3);
      wait_pe(); check("re_duty5", 32'(o_duty), 5);
      wait_pe(); check("re_duty7", 32'(o_duty), 7);
      check("re_ramping", 32'(o_ramping), 1);
      pulse(1, 0, 0, 0, 3'd0);
      check("off_duty", 32'(o_duty), 0);
      check("off_stage", 32'(o_stage), 0);
      check("off_light", 32'(o_light), 0);
      check("off_motor_lag", 32'(o_motor), 1);
      step(1);
      check("off_motor", 32'(o_motor), 0);
      step(1);
      check("off_ramping", 32'(o_ramping), 0);

      // 5: priority and saturation
      pulse(1, 1, 0, 0, 3'd0);
      check("off_beats_up", 32'(o_stage), 0);
      pulse(0, 1, 0, 0, 3'd0);
      pulse(0, 1, 0, 0, 3'd0);
      pulse(0, 1, 0, 0, 3'd0);
      pulse(0, 1, 0, 0, 3'd0);
      check("up_saturate", 32'(o_stage), 3);
      check("up_sat_light", 32'(o_light), 32'b111);
      pulse(0, 0, 0, 1, 3'd5);
      check("sel5_ignored_s3", 32'(o_stage), 3);
      pulse(0, 0, 1, 1, 3'd1);
      check("sel_beats_down", 32'(o_stage), 1);
      check("sel1_light", 32'(o_light), 32'b001);
      pulse(1, 0, 0, 0, 3'd0);
      pulse(0, 0, 1, 0, 3'd0);
      check("down_saturate", 32'(o_stage), 0);
      check("down_sat_light", 32'(o_light), 0);
      pulse(0, 0, 0, 1, 3'd5);
      check("sel5_ignored_s0", 32'(o_stage), 0);

      // 6: async reset during a ramp-down 10->6
      pulse(0, 0, 0, 1, 3'd3);
      repeat (5) wait_pe();
      check("r6_duty10", 32'(o_duty), 10);
      pulse(0, 0, 1, 0, 3'd0);
      wait_pe();
      check("r6_duty8", 32'(o_duty), 8);
      #3 i_reset = 1'b1;
      #1;
      check_idle("async_rst");
      step(2);
      i_reset = 1'b0;
      step(3);
      check_idle("post_rst");
      count_motor(60, highs);
      check("post_rst_motor", 32'(highs), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
